response_router: RTL and testbench
==================================

// Module: response_router
// PURPOSE
//  Return path for a round-robin-arbitrated shared resource (e.g. L2/memory port).
//  On each issued grant it records the winning requestor index in order; when the
//  resource returns in-order responses it routes each one back to the originator.
//  Sits beside the arbiter: arbiter selects the forward direction, this block demuxes the reverse.
// PARAMETERS
//  NUM_REQUESTORS   4   number of requestors; width of one-hot grant/response vectors
//  MAX_OUTSTANDING  8   max issued-but-unanswered transactions; power of two, >=2
//  DATA_WIDTH       32  response payload width
// PORTS
//  clk              in   1                clock
//  reset            in   1                synchronous, active-high reset
//  grant_oh         in   NUM_REQUESTORS   one-hot winner from arbiter
//  grant_valid      in   1                transaction issued to resource this cycle
//  issue_full       out  1                tracker full; issuer must gate grant_valid
//  response_valid   in   1                resource returns one response this cycle
//  response_data    in   DATA_WIDTH       response payload
//  resp_valid_oh    out  NUM_REQUESTORS   one-hot delivery strobe to originator
//  resp_data        out  DATA_WIDTH       payload accompanying resp_valid_oh
//  pending_oh       out  NUM_REQUESTORS   bit i set while requestor i has >=1 outstanding
//  protocol_error   out  1                sticky; set on any protocol violation
// BEHAVIOUR
//  - Clock/reset: single clock; reset synchronous active-high. After reset: resp_valid_oh=0,
//    resp_data=0, pending_oh=0, issue_full=0, protocol_error=0, tracker empty, all counters 0.
//  - Push: grant_valid with one-hot grant_oh encodes index (clog2(NUM_REQUESTORS) bits)
//    and appends to in-order tracker; per-requestor count[idx] += 1.
//  - Pop: response_valid removes head index; next cycle resp_valid_oh = 1<<head and
//    resp_data = response_data (latency exactly 1, registered); count[head] -= 1.
//  - resp_valid_oh is 0 in any cycle not following an accepted pop; resp_data holds last value.
//  - issue_full = (occupancy == MAX_OUTSTANDING), combinational from registered occupancy.
//  - Push and pop in same cycle: both take effect, occupancy unchanged; accepted even when
//    full (pop frees slot). Same idx push+pop: count[idx] unchanged.
//  - Push while full without pop: dropped, protocol_error set.
//  - Pop while empty: dropped, no delivery, protocol_error set; no bypass from same-cycle push.
//  - grant_valid with grant_oh zero or multi-hot: push dropped, protocol_error set.
//  - pending_oh[i] = (count[i] != 0), registered alongside counts (reflects post-update state).
//  - Pointers wrap modulo MAX_OUTSTANDING; occupancy is clog2(MAX_OUTSTANDING)+1 bits.
//  - protocol_error clears only on reset. Reset mid-operation discards all outstanding
//    entries; no delivery pulse in the cycle after reset.
// CONFIGURATION
//  RESPONSE_ROUTER_PERF_EN defined: adds outputs perf_issue_count (32b, wrapping count of
//    accepted pushes) and perf_peak_occupancy (clog2(MAX_OUTSTANDING)+1 bits, high-water
//    mark of occupancy); both reset to 0.
//  Undefined: those ports and their logic are absent; all other behaviour identical.
// STRUCTURE
//  - Shared defines package: requestor_idx_t typedef and the one-hot->index encode function
//    (reused by arbiter-side logic).
//  - One sub-module: sync_fifo holding requestor_idx_t entries (depth MAX_OUTSTANDING),
//    provides full/empty/occupancy; per-requestor counters, delivery regs, error logic in top.
// TESTING
//  1. Reset, idle -> all outputs 0; issue_full=0; protocol_error=0.
//  2. Push grant_oh=4'b0010, then 4'b1000; two responses 0xA5, 0x5A -> resp_valid_oh
//     0010/0xA5 then 1000/0x5A, each 1 cycle after response_valid; pending_oh returns to 0.
//  3. Push 8x grant_oh=4'b0001 -> issue_full=1, pending_oh=0001; 9th push alone -> dropped,
//     protocol_error=1; simultaneous push+pop at full -> accepted, issue_full stays 1.
//  4. response_valid with tracker empty -> resp_valid_oh stays 0, protocol_error=1.
//  5. grant_valid with grant_oh=4'b0110 -> no push, occupancy 0, protocol_error=1.
//  6. 3 pushes outstanding, assert reset 1 cycle -> occupancy 0, pending_oh=0,
//     protocol_error=0; later response -> treated as empty-pop error.

Source files
------------

// File: rtl/response_router_pkg.sv
// -----------------------------------------------------------------------------
// response_router_pkg
// Shared definitions for the arbiter / response-router pair.
//   MAX_REQUESTORS   upper bound on requestor count supported by requestor_idx_t
//   requestor_idx_t  encoded requestor index stored in the in-order tracker
//   requestor_vec_t  one-hot requestor vector, zero-extended to MAX_REQUESTORS
//   is_onehot()      true when exactly one bit of the vector is set
//   onehot_to_idx()  one-hot -> binary index encode (result meaningful only
//                    for one-hot input)
// -----------------------------------------------------------------------------
package response_router_pkg;

  localparam int unsigned MAX_REQUESTORS = 32;
  localparam int unsigned REQ_IDX_W      = $clog2(MAX_REQUESTORS);

  typedef logic [REQ_IDX_W-1:0]      requestor_idx_t;
  typedef logic [MAX_REQUESTORS-1:0] requestor_vec_t;

  function automatic logic is_onehot(input requestor_vec_t v);
    return (v != '0) && ((v & (v - requestor_vec_t'(1))) == '0);
  endfunction

  function automatic requestor_idx_t onehot_to_idx(input requestor_vec_t v);
    requestor_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQUESTORS; i++) begin
      if (v[i]) idx = idx | requestor_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/response_router_if.sv
// -----------------------------------------------------------------------------
// response_router_if
// Grant/response bus between the arbiter side, the shared resource and the
// response router.
//   grant_oh, grant_valid           arbiter -> router (issue record)
//   issue_full                      router  -> issuer (gate grant_valid)
//   response_valid, response_data   resource -> router
//   resp_valid_oh, resp_data        router  -> requestors (delivery)
//   pending_oh, protocol_error      router status
//   perf_issue_count, perf_peak_occupancy  only with RESPONSE_ROUTER_PERF_EN
// Modports: slave = router, master = surrounding logic / testbench.
// -----------------------------------------------------------------------------
interface response_router_if #(
  parameter int unsigned NUM_REQUESTORS  = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DATA_WIDTH      = 32
);

  logic [NUM_REQUESTORS-1:0] grant_oh;
  logic                      grant_valid;
  logic                      issue_full;
  logic                      response_valid;
  logic [DATA_WIDTH-1:0]     response_data;
  logic [NUM_REQUESTORS-1:0] resp_valid_oh;
  logic [DATA_WIDTH-1:0]     resp_data;
  logic [NUM_REQUESTORS-1:0] pending_oh;
  logic                      protocol_error;

`ifdef RESPONSE_ROUTER_PERF_EN
  logic [31:0]                        perf_issue_count;
  logic [$clog2(MAX_OUTSTANDING):0]   perf_peak_occupancy;

  modport slave (
    input  grant_oh, grant_valid, response_valid, response_data,
    output issue_full, resp_valid_oh, resp_data, pending_oh, protocol_error,
           perf_issue_count, perf_peak_occupancy
  );
  modport master (
    output grant_oh, grant_valid, response_valid, response_data,
    input  issue_full, resp_valid_oh, resp_data, pending_oh, protocol_error,
           perf_issue_count, perf_peak_occupancy
  );
`else
  modport slave (
    input  grant_oh, grant_valid, response_valid, response_data,
    output issue_full, resp_valid_oh, resp_data, pending_oh, protocol_error
  );
  modport master (
    output grant_oh, grant_valid, response_valid, response_data,
    input  issue_full, resp_valid_oh, resp_data, pending_oh, protocol_error
  );
`endif

endinterface

// File: rtl/response_router_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// In-order tracker of requestor indices. Caller qualifies wr_en/rd_en (no
// write when full unless reading, no read when empty); the FIFO just obeys.
//   clk, reset   clock, synchronous active-high reset
//   wr_en/wr_data  append entry
//   rd_en          drop head entry
//   rd_data        current head entry (combinational)
//   full, empty, occupancy  status from registered occupancy
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo
  import response_router_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  requestor_idx_t             wr_data,
  input  logic                       rd_en,
  output requestor_idx_t             rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  requestor_idx_t     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(wr_en) - OCC_W'(rd_en);
    end
  end

  assign rd_data   = mem[rd_ptr];
  assign full      = (occ == OCC_W'(DEPTH));
  assign empty     = (occ == '0);
  assign occupancy = occ;

endmodule

// File: rtl/response_router.sv
// -----------------------------------------------------------------------------
// response_router
// Return path for a round-robin-arbitrated shared resource. Each accepted grant
// records the winner's index in order; each in-order response from the
// resource is delivered one cycle later to the recorded originator.
//   clk    clock
//   reset  synchronous, active-high
//   bus    response_router_if.slave: grant_oh/grant_valid in, issue_full out,
//          response_valid/response_data in, resp_valid_oh/resp_data out,
//          pending_oh out, protocol_error out (sticky until reset)
// Optional: RESPONSE_ROUTER_PERF_EN adds perf_issue_count (accepted pushes,
// wrapping) and perf_peak_occupancy (occupancy high-water mark).
// NUM_REQUESTORS must not exceed response_router_pkg::MAX_REQUESTORS.
// -----------------------------------------------------------------------------
module response_router
  import response_router_pkg::*;
#(
  parameter int unsigned NUM_REQUESTORS  = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input logic              clk,
  input logic              reset,
  response_router_if.slave bus
);

  localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING) + 1;

  requestor_vec_t            grant_wide;
  logic                      grant_legal;
  requestor_idx_t            push_idx;
  requestor_idx_t            head_idx;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [OCC_W-1:0]          occupancy;
  logic                      push_acc;
  logic                      pop_acc;
  logic                      proto_viol;

  logic [OCC_W-1:0]          count      [NUM_REQUESTORS];
  logic [OCC_W-1:0]          count_next [NUM_REQUESTORS];
  logic [NUM_REQUESTORS-1:0] pending_q;
  logic [NUM_REQUESTORS-1:0] resp_valid_q;
  logic [DATA_WIDTH-1:0]     resp_data_q;
  logic                      error_q;

  assign grant_wide  = requestor_vec_t'(bus.grant_oh);
  assign grant_legal = is_onehot(grant_wide);
  assign push_idx    = onehot_to_idx(grant_wide);

  // A pop in the same cycle frees the slot, so a push at full is still legal;
  // the reverse (pop on empty bypassing a same-cycle push) is not supported.
  assign pop_acc  = bus.response_valid && !fifo_empty;
  assign push_acc = bus.grant_valid && grant_legal && (!fifo_full || pop_acc);

  assign proto_viol = (bus.grant_valid && !grant_legal)
                   || (bus.grant_valid && grant_legal && fifo_full && !pop_acc)
                   || (bus.response_valid && fifo_empty);

  sync_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (push_acc),
    .wr_data   (push_idx),
    .rd_en     (pop_acc),
    .rd_data   (head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQUESTORS; i++) begin
      count_next[i] = count[i];
      if (push_acc && (push_idx == requestor_idx_t'(i))) count_next[i] = count_next[i] + OCC_W'(1);
      if (pop_acc && (head_idx == requestor_idx_t'(i)))  count_next[i] = count_next[i] - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQUESTORS; i++) count[i] <= '0;
      pending_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      count <= count_next;
      for (int unsigned i = 0; i < NUM_REQUESTORS; i++) pending_q[i] <= (count_next[i] != '0);
      resp_valid_q <= pop_acc ? (NUM_REQUESTORS'(1) << head_idx) : '0;
      if (pop_acc) resp_data_q <= bus.response_data;
      if (proto_viol) error_q <= 1'b1;
    end
  end

  assign bus.issue_full     = (occupancy == OCC_W'(MAX_OUTSTANDING));
  assign bus.resp_valid_oh  = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.pending_oh     = pending_q;
  assign bus.protocol_error = error_q;

`ifdef RESPONSE_ROUTER_PERF_EN
  logic [31:0]      perf_issue_q;
  logic [OCC_W-1:0] perf_peak_q;
  logic [OCC_W-1:0] occ_next;

  assign occ_next = occupancy + OCC_W'(push_acc) - OCC_W'(pop_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_q <= '0;
      perf_peak_q  <= '0;
    end else begin
      if (push_acc) perf_issue_q <= perf_issue_q + 32'd1;
      if (occ_next > perf_peak_q) perf_peak_q <= occ_next;
    end
  end

  assign bus.perf_issue_count    = perf_issue_q;
  assign bus.perf_peak_occupancy = perf_peak_q;
`endif

endmodule

// File: tb/tb_response_router.sv
// -----------------------------------------------------------------------------
// tb_response_router
// Directed stimulus; expected deliveries go into a scoreboard queue with the
// cycle they must appear in, and a negedge monitor checks every delivery.
// -----------------------------------------------------------------------------
module tb_response_router;

  localparam int unsigned NR = 4;
  localparam int unsigned MO = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  response_router_if #(
    .NUM_REQUESTORS  (NR),
    .MAX_OUTSTANDING (MO),
    .DATA_WIDTH      (DW)
  ) bus ();

  response_router #(
    .NUM_REQUESTORS  (NR),
    .MAX_OUTSTANDING (MO),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0] oh;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every delivery pulse must match the oldest expected entry,
  // including the cycle it was due in.
  always @(negedge clk) begin
    if (bus.resp_valid_oh !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got oh=%b data=%0h expected none (cycle %0d)",
                 bus.resp_valid_oh, bus.resp_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("deliv_oh",   32'(bus.resp_valid_oh), 32'(e.oh));
        chk("deliv_data", bus.resp_data,          e.data);
        chk("deliv_cyc",  32'(cyc),               32'(e.cyc));
      end
    end
  end

  // Called at a negedge: drive one cycle of inputs, record the expected
  // delivery (exp_oh == 0 means none), return at the next negedge.
  task automatic step(input logic gv, input logic [NR-1:0] goh,
                      input logic rv, input logic [DW-1:0] rd,
                      input logic [NR-1:0] exp_oh);
    exp_t e;
    bus.grant_valid    = gv;
    bus.grant_oh       = goh;
    bus.response_valid = rv;
    bus.response_data  = rd;
    if (exp_oh != '0) begin
      e.oh   = exp_oh;
      e.data = rd;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.grant_valid    = 1'b0;
    bus.grant_oh       = '0;
    bus.response_valid = 1'b0;
    bus.response_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.grant_valid    = 1'b0;
    bus.grant_oh       = '0;
    bus.response_valid = 1'b0;
    bus.response_data  = '0;
    reset              = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1. reset state
    chk("rst_resp_valid", 32'(bus.resp_valid_oh),  32'h0);
    chk("rst_resp_data",  bus.resp_data,           32'h0);
    chk("rst_pending",    32'(bus.pending_oh),     32'h0);
    chk("rst_full",       32'(bus.issue_full),     32'h0);
    chk("rst_error",      32'(bus.protocol_error), 32'h0);
    step(0, '0, 0, '0, '0);
    chk("idle_error",     32'(bus.protocol_error), 32'h0);

    // 2. two requestors, in-order return
    step(1, 4'b0010, 0, '0, '0);
    step(1, 4'b1000, 0, '0, '0);
    chk("t2_pending_both", 32'(bus.pending_oh), 32'hA);
    step(0, '0, 1, 32'hA5, 4'b0010);
    chk("t2_pending_one",  32'(bus.pending_oh), 32'h8);
    step(0, '0, 1, 32'h5A, 4'b1000);
    chk("t2_pending_none", 32'(bus.pending_oh), 32'h0);
    step(0, '0, 0, '0, '0);
    chk("t2_data_hold",    bus.resp_data,              32'h5A);
    chk("t2_valid_idle",   32'(bus.resp_valid_oh),     32'h0);
    chk("t2_error",        32'(bus.protocol_error),    32'h0);

    // 3. fill to capacity, overflow, push+pop at full, drain
    for (int i = 0; i < 8; i++) begin
      chk("t3_not_full", 32'(bus.issue_full), 32'h0);
      step(1, 4'b0001, 0, '0, '0);
    end
    chk("t3_full",        32'(bus.issue_full),     32'h1);
    chk("t3_pending",     32'(bus.pending_oh),     32'h1);
    chk("t3_no_err_yet",  32'(bus.protocol_error), 32'h0);
    step(1, 4'b0001, 0, '0, '0);
    chk("t3_overflow_err", 32'(bus.protocol_error), 32'h1);
    chk("t3_still_full",   32'(bus.issue_full),     32'h1);
    step(1, 4'b0001, 1, 32'h33, 4'b0001);
    chk("t3_pushpop_full", 32'(bus.issue_full),     32'h1);
    chk("t3_pushpop_pend", 32'(bus.pending_oh),     32'h1);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 32'h40 + 32'(i), 4'b0001);
    end
    chk("t3_drained_full", 32'(bus.issue_full), 32'h0);
    chk("t3_drained_pend", 32'(bus.pending_oh), 32'h0);
    chk("t3_sticky_err",   32'(bus.protocol_error), 32'h1);
    do_reset();
    chk("t3_err_cleared",  32'(bus.protocol_error), 32'h0);

    // 4. pop while empty, and no bypass from a same-cycle push
    step(0, '0, 1, 32'h77, '0);
    chk("t4_empty_pop_err", 32'(bus.protocol_error), 32'h1);
    step(0, '0, 0, '0, '0);
    do_reset();
    step(1, 4'b0100, 1, 32'h55, '0);
    chk("t4_nobypass_err",  32'(bus.protocol_error), 32'h1);
    chk("t4_nobypass_pend", 32'(bus.pending_oh),     32'h4);
    step(0, '0, 1, 32'h66, 4'b0100);
    chk("t4_late_pend",     32'(bus.pending_oh),     32'h0);
    do_reset();

    // 5. illegal grant vectors
    step(1, 4'b0110, 0, '0, '0);
    chk("t5_multi_err",  32'(bus.protocol_error), 32'h1);
    chk("t5_multi_pend", 32'(bus.pending_oh),     32'h0);
    chk("t5_multi_full", 32'(bus.issue_full),     32'h0);
    do_reset();
    step(1, 4'b0000, 0, '0, '0);
    chk("t5_zero_err",   32'(bus.protocol_error), 32'h1);
    chk("t5_zero_pend",  32'(bus.pending_oh),     32'h0);
    do_reset();

    // 6. reset with transactions outstanding
    step(1, 4'b0100, 0, '0, '0);
    step(1, 4'b0001, 0, '0, '0);
    step(1, 4'b1000, 0, '0, '0);
    chk("t6_pending_pre", 32'(bus.pending_oh), 32'hD);
    do_reset();
    chk("t6_pending_post", 32'(bus.pending_oh),     32'h0);
    chk("t6_full_post",    32'(bus.issue_full),     32'h0);
    chk("t6_err_post",     32'(bus.protocol_error), 32'h0);
    chk("t6_valid_post",   32'(bus.resp_valid_oh),  32'h0);
    step(0, '0, 1, 32'h99, '0);
    chk("t6_late_resp_err", 32'(bus.protocol_error), 32'h1);
    step(0, '0, 0, '0, '0);
    step(0, '0, 0, '0, '0);

    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
